// File: rtl/mac_pkg.sv
// Shared constants and beat layout for the MAC packet FIFO family.
package mac_pkg;

    localparam int MAC_FIFO_DW = 11;
    localparam int MAC_FIFO_AW = 4;

    typedef struct packed {
        logic                   last;
        logic [MAC_FIFO_DW-1:0] data;
    } mac_beat_t;

endpackage

// File: rtl/mac_fifo_ram.sv
// Packet FIFO storage: synchronous write, asynchronous read, no reset.
module mac_fifo_ram #(
    parameter int W  = 12,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mac_pkt_fifo.sv
// Packet FIFO: frames are staged between cptr and wptr and become visible
// to the reader only when their last beat commits.
module mac_pkt_fifo
    import mac_pkg::*;
#(
    parameter int DW        = MAC_FIFO_DW,
    parameter int AW        = MAC_FIFO_AW,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write,
    input  logic [DW-1:0] wdata,
    input  logic          wlast,
    input  logic          wabort,
    output logic          full,
    output logic          almost_full,
    output logic          commit,
    output logic          drop,
    input  logic          read,
    output logic [DW-1:0] rdata,
    output logic          rlast,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic [AW:0]   frame_cnt,
    output logic          frame_avail
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic [AW:0] rptr, cptr, wptr, frames, used;
    logic        ovf, commit_q, drop_q;
    logic        wacc, racc, ovf_hit, ovf_drop, abort_ev, commit_ev;
    beat_t       head, wbeat;

    assign used  = wptr - rptr;
    assign count = cptr - rptr;
    assign full  = (used == DEPTH_V);
    assign empty = (count == '0);

    assign almost_full  = int'(used) >= AFULL_TH;
    assign almost_empty = int'(count) <= AEMPTY_TH;

    assign wacc      = write & ~full & ~ovf & ~wabort;
    assign racc      = read & ~empty;
    // Any write that finds no room (or follows one that didn't) belongs to a doomed frame.
    assign ovf_hit   = write & ~wabort & (ovf | full);
    assign ovf_drop  = ovf_hit & wlast;
    assign abort_ev  = wabort & ((wptr != cptr) | ovf);
    assign commit_ev = wacc & wlast;

    assign wbeat = '{last: wlast, data: wdata};

    mac_fifo_ram #(.W(DW + 1), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wacc),
        .waddr (wptr[AW-1:0]),
        .wdata (wbeat),
        .raddr (rptr[AW-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr     <= '0;
            cptr     <= '0;
            wptr     <= '0;
            frames   <= '0;
            ovf      <= 1'b0;
            commit_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            commit_q <= commit_ev;
            drop_q   <= abort_ev | ovf_drop;
            if (racc) rptr <= rptr + 1'b1;
            if (abort_ev | ovf_drop) begin
                wptr <= cptr;
                ovf  <= 1'b0;
            end else begin
                if (wacc)    wptr <= wptr + 1'b1;
                if (ovf_hit) ovf  <= 1'b1;
            end
            if (commit_ev) cptr <= wptr + 1'b1;
            if (commit_ev && !(racc && head.last))
                frames <= frames + 1'b1;
            else if (!commit_ev && racc && head.last)
                frames <= frames - 1'b1;
        end
    end

    assign commit      = commit_q;
    assign drop        = drop_q;
    assign frame_cnt   = frames;
    assign frame_avail = (frames != '0);
    assign rdata       = empty ? '0 : head.data;
    assign rlast       = empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_mac_pkt_fifo.sv
// Randomised scoreboard bench for mac_pkt_fifo against a queue-based frame model.
module tb_mac_pkt_fifo;

    localparam int DW = 11;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write = 1'b0, wlast = 1'b0, wabort = 1'b0, read = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          full, almost_full, commit, drop, rlast, empty, almost_empty, frame_avail;
    logic [DW-1:0] rdata;
    logic [AW:0]   count, frame_cnt;

    mac_pkt_fifo #(.DW(DW), .AW(AW), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .write(write), .wdata(wdata), .wlast(wlast),
        .wabort(wabort), .full(full), .almost_full(almost_full), .commit(commit),
        .drop(drop), .read(read), .rdata(rdata), .rlast(rlast), .empty(empty),
        .almost_empty(almost_empty), .count(count), .frame_cnt(frame_cnt),
        .frame_avail(frame_avail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } beat_s;

    // Model: committed beats, staged frame, overflow flag, frame count.
    beat_s mq[$];
    beat_s sq[$];
    bit    m_ovf;
    int    m_frames;
    // Scoreboard queues consumed by the monitor.
    beat_s exp_q[$];
    int    evt_q[$];   // 1 = commit, 2 = drop

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete(); sq.delete(); exp_q.delete(); evt_q.delete();
        m_ovf = 0; m_frames = 0;
    endtask

    task automatic model_step(input bit w, input logic [DW-1:0] d, input bit l,
                              input bit a, input bit r);
        int    used;
        bit    racc;
        beat_s b;
        used = mq.size() + sq.size();
        racc = r && (mq.size() > 0);
        if (a) begin
            if (sq.size() > 0 || m_ovf) begin
                sq.delete(); m_ovf = 0; evt_q.push_back(2);
            end
        end else if (w) begin
            if (m_ovf || used == DEPTH) begin
                if (l) begin sq.delete(); m_ovf = 0; evt_q.push_back(2); end
                else m_ovf = 1;
            end else begin
                b.last = l; b.data = d;
                sq.push_back(b);
                if (l) begin
                    foreach (sq[i]) begin mq.push_back(sq[i]); exp_q.push_back(sq[i]); end
                    sq.delete();
                    m_frames++;
                    evt_q.push_back(1);
                end
            end
        end
        if (racc) begin
            b = mq.pop_front();
            if (b.last) m_frames--;
        end
    endtask

    task automatic check_flags();
        int used, cnt;
        used = mq.size() + sq.size();
        cnt  = mq.size();
        chk("empty", int'(empty), int'(cnt == 0));
        chk("full", int'(full), int'(used == DEPTH));
        chk("count", int'(count), cnt);
        chk("frame_cnt", int'(frame_cnt), m_frames);
        chk("frame_avail", int'(frame_avail), int'(m_frames != 0));
        chk("almost_full", int'(almost_full), int'(used >= 12));
        chk("almost_empty", int'(almost_empty), int'(cnt <= 2));
        if (cnt == 0) begin
            chk("rdata_gated", int'(rdata), 0);
            chk("rlast_gated", int'(rlast), 0);
        end
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit l,
                        input bit a, input bit r);
        write = w; wdata = d; wlast = l; wabort = a; read = r;
        @(posedge clk);
        model_step(w, d, l, a, r);
        #1;
        check_flags();
    endtask

    task automatic do_reset(input int n);
        write = 0; wlast = 0; wabort = 0; read = 0; rst = 1;
        repeat (n) begin
            @(posedge clk);
            model_reset();
        end
        #1;
        check_flags();
        chk("rst_commit", int'(commit), 0);
        chk("rst_drop", int'(drop), 0);
        rst = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read beat or an event pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (read && !empty) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    beat_s b;
                    b = exp_q.pop_front();
                    chk("rdata", int'(rdata), int'(b.data));
                    chk("rlast", int'(rlast), int'(b.last));
                end
            end
            chk("commit_drop_excl", int'(commit && drop), 0);
            if (commit || drop) begin
                if (evt_q.size() == 0) chk("evt_unexpected", commit ? 1 : 2, 0);
                else chk("event", commit ? 1 : 2, evt_q.pop_front());
            end else if (evt_q.size() > 0) begin
                chk("event_missing", 0, evt_q.pop_front());
            end
            begin
                logic [AW:0] c_r, w_r;
                c_r = dut.cptr - dut.rptr;
                w_r = dut.wptr - dut.rptr;
                chk("ptr_invariant", int'(c_r <= w_r && w_r <= DEPTH), 1);
            end
        end
    end

    initial begin
        do_reset(2);

        // Basic 5-beat frame, then read it back.
        for (int i = 1; i <= 5; i++) step(1, DW'(i), i == 5, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 1);

        // Abort after 3 beats, then a 2-beat frame survives intact.
        for (int i = 0; i < 3; i++) step(1, DW'(16 + i), 0, 0, 0);
        step(1, DW'(99), 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, DW'(32), 0, 0, 0);
        step(1, DW'(33), 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);

        // 20-beat frame overflows and is dropped on its last beat.
        for (int i = 1; i <= 20; i++) step(1, DW'(64 + i), i == 20, 0, 0);
        step(0, 0, 0, 0, 0);

        // Frame A committed, frame B streamed while A drains; B commits with A's last read.
        for (int i = 0; i < 4; i++) step(1, DW'(128 + i), i == 3, 0, 0);
        for (int i = 0; i < 10; i++) step(1, DW'(256 + i), i == 9, 0, i >= 6);
        repeat (12) step(0, 0, 0, 0, 1);

        // 40 single-beat frames with random read gaps across pointer wrap.
        for (int i = 0; i < 40; i++) step(1, DW'($urandom_range(0, 2047)), 1, 0, $urandom_range(0, 1) == 1);
        repeat (20) step(0, 0, 0, 0, 1);

        // Random mix of writes, lasts, aborts and reads.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, DW'($urandom_range(0, 2047)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        repeat (20) step(0, 0, 0, 0, 1);

        // Mid-frame reset: no drop pulse, everything back to reset values.
        step(1, DW'(5), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, DW'(500 + i), 0, 0, 0);
        do_reset(1);
        step(0, 0, 0, 0, 0);
        chk("post_rst_drop", int'(drop), 0);
        step(0, 0, 0, 0, 1);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("evt_q_drained", evt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
